inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised instruction fetch unit with a prefetch queue. It replaces the single-entry PC/IF_ID pair of the five-stage MIPS core. It drives the instruction ROM every cycle the queue has room and buffers {pc, instruction} pairs in a circular FIFO of configurable depth. ID consumes entries through a dequeue handshake. Jump and exception/interrupt redirects flush the queue, with optional MIPS branch-delay-slot retention.

## Interface
- DATA_W, 32, instruction width
- ADDR_W, 32, PC / instruction-address width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset
- DELAY_SLOT, 0, 1 = retain the delay-slot instruction on a jump; 0 = flush everything
- Reset is synchronous and active-high; the design uses one clock.
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  DATA_W  ROM read data; combinational response to instAddr in the same cycle
- jCe  in  1  jump taken by the ID head instruction
- jAddr  in  ADDR_W  jump target
- excpt  in  1  exception/interrupt redirect from Ctrl
- ejpc  in  ADDR_W  exception/interrupt target
- deq  in  1  ID consumes the head entry this cycle
- romCe  out  1  ROM enable; a push occurs in every cycle it is high
- instAddr  out  ADDR_W  current fetch PC
- valid_o  out  1  queue non-empty
- inst_o  out  DATA_W  head instruction; 0 (NOP) when empty
- pc_o  out  ADDR_W  head PC; 0 when empty
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- **State:**
  - pc register
  - rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH
  - count
  - pend flag and pend_tgt register (DELAY_SLOT=1 only)
- **Dequeue:**
  - deq_fire = deq & valid_o.
  - deq while empty is ignored.
- **Fetch:**
  - romCe = !rst & !redir & (count<DEPTH | deq_fire), where redir = excpt | jCe.
  - When romCe is high: write {instAddr, instruction} at wr_ptr.
  - Next pc = pend ? pend_tgt : pc+4, and pend is cleared.
- **Count:** next count = count + push − deq_fire. Push and pop together when full keeps count at DEPTH.
- **Exception (excpt=1):**
  - All entries are discarded; count=0 and pointers reset to 0.
  - pc=ejpc and pend is cleared.
  - jCe and deq are ignored that cycle.
- **Jump (jCe=1, excpt=0):** the head entry is always consumed, regardless of deq.
  - DELAY_SLOT=0: flush all entries; pc=jAddr.
  - DELAY_SLOT=1 with count≥2: keep only the entry at rd_ptr+1 (count=1); pc=jAddr.
  - DELAY_SLOT=1 with count≤1: flush; pc is unchanged; pend=1, pend_tgt=jAddr. The next push fetches the delay slot at pc, then pc=jAddr.
- **Priority:** rst > excpt > jCe > normal fetch/dequeue.
- **Arithmetic:** pc+4 wraps modulo 2^ADDR_W. No alignment checking is done; that is handled in ID/EX.

## Timing
- **Reset values** (end of any cycle with rst=1):
  - pc=RESET_PC, pointers=0, count=0, pend=0.
  - Outputs: romCe=0, valid_o=0, inst_o=0, pc_o=0, instAddr=RESET_PC.
  - Reset asserted mid-operation discards all entries and any pending target.
- **Latency:** an instruction fetched in cycle t is at the head in t+1 at the earliest (empty queue, no redirect).
- **Redirect penalty:** redirect in cycle t → instAddr=target and romCe=1 in t+1 → target instruction valid at head in t+2.
- **No-deq fill:** with deq held low, romCe is high for exactly DEPTH consecutive cycles, then low while full.
- **Full with deq:** a full queue with deq=1 fetches and consumes in the same cycle, giving full throughput of one instruction per cycle.
- **Outputs:** inst_o/pc_o/valid_o/count are register-derived, not combinational from inputs. romCe is combinational from deq, jCe, excpt and rst.

## Test plan
- **Reset:** RESET_PC=0, DEPTH=4, deq=0 after rst release → pushes at PCs 0, 4, 8, 12 on four cycles; romCe low from the fifth cycle; count=4; pc_o=0 with head inst = ROM[0].
- **Streaming:** deq=1 every cycle from the first valid → count stays 1; pc_o increments by 4 each cycle; no bubbles.
- **Jump, DELAY_SLOT=0:** head at 0x10, count=3, jCe with jAddr=0x100 → count=0 next cycle; instAddr=0x100; valid head pc_o=0x100 two cycles after jCe.
- **Jump, DELAY_SLOT=1:**
  - count=3, head 0x10 → next cycle count=1, pc_o=0x14, instAddr=0x100.
  - count=1 case → instAddr fetches 0x14 first, then 0x100.
- **Exception with simultaneous jump:** excpt=1 with ejpc=0x80 while jCe=1 with jAddr=0x100 and pend=1 → queue empty, instAddr=0x80, pend=0; 0x100 is never fetched.
- **Reset mid-operation and wrap-around:** rst while full after pointer wrap → all outputs at reset values next cycle; fetch resumes from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit with a circular prefetch queue of {pc, instruction} pairs; jumps/exceptions flush it.
// Latency: fetch in cycle t is at the head in t+1; a redirect in t gives the target at the head in t+2.
// Backpressure: romCe drops while the queue is full unless ID dequeues in the same cycle.
module inst_fetch_queue #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                DELAY_SLOT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          instruction,
    input  logic                       jCe,
    input  logic [ADDR_W-1:0]          jAddr,
    input  logic                       excpt,
    input  logic [ADDR_W-1:0]          ejpc,
    input  logic                       deq,
    output logic                       romCe,
    output logic [ADDR_W-1:0]          instAddr,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              pend_q, pend_d;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              redir, deq_fire, push, not_full;

    assign redir    = excpt | jCe;
    assign valid_o  = (cnt_q != '0);
    assign deq_fire = deq & valid_o;
    assign not_full = (cnt_q < CW'(DEPTH));
    assign push     = !rst && !redir && (not_full || deq_fire);

    assign romCe    = push;
    assign instAddr = pc_q;
    assign inst_o   = valid_o ? mem_q[rd_q].inst : '0;
    assign pc_o     = valid_o ? mem_q[rd_q].pc   : '0;
    assign count    = cnt_q;

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        if (excpt) begin
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            pc_d   = ejpc;
            pend_d = 1'b0;
        end else if (jCe) begin
            if ((DELAY_SLOT != 0) && (cnt_q >= CW'(2))) begin
                // Head is the jump itself; the entry behind it is the delay slot.
                rd_d   = rd_q + PW'(1);
                wr_d   = rd_q + PW'(1) + PW'(1);
                cnt_d  = CW'(1);
                pc_d   = jAddr;
                pend_d = 1'b0;
            end else if (DELAY_SLOT != 0) begin
                // Delay slot not fetched yet: fetch it at pc, then go to the target.
                rd_d       = '0;
                wr_d       = '0;
                cnt_d      = '0;
                pend_d     = 1'b1;
                pend_tgt_d = jAddr;
            end else begin
                rd_d   = '0;
                wr_d   = '0;
                cnt_d  = '0;
                pc_d   = jAddr;
                pend_d = 1'b0;
            end
        end else begin
            if (push) begin
                wr_d   = wr_q + PW'(1);
                pc_d   = pend_q ? pend_tgt_q : pc_q + ADDR_W'(4);
                pend_d = 1'b0;
            end
            if (deq_fire) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= '{pc: pc_q, inst: instruction};
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: two instances (DELAY_SLOT=0 and 1) checked every cycle against a queue model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, jce, excpt, deq;
    logic [31:0] jaddr, ejpc;

    logic [31:0] inst_in [2];
    logic        rce     [2];
    logic [31:0] iaddr   [2];
    logic        vld     [2];
    logic [31:0] insto   [2];
    logic [31:0] pco     [2];
    logic [2:0]  cnt     [2];

    ent_t        mq    [2][$];
    logic [31:0] m_pc  [2];
    logic        m_pend[2];
    logic [31:0] m_tgt [2];
    logic        rc    [2];
    logic        armed;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    assign inst_in[0] = rom(iaddr[0]);
    assign inst_in[1] = rom(iaddr[1]);

    inst_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .DELAY_SLOT(0)) u_ds0 (
        .clk(clk), .rst(rst), .instruction(inst_in[0]), .jCe(jce), .jAddr(jaddr),
        .excpt(excpt), .ejpc(ejpc), .deq(deq), .romCe(rce[0]), .instAddr(iaddr[0]),
        .valid_o(vld[0]), .inst_o(insto[0]), .pc_o(pco[0]), .count(cnt[0]));

    inst_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .DELAY_SLOT(1)) u_ds1 (
        .clk(clk), .rst(rst), .instruction(inst_in[1]), .jCe(jce), .jAddr(jaddr),
        .excpt(excpt), .ejpc(ejpc), .deq(deq), .romCe(rce[1]), .instAddr(iaddr[1]),
        .valid_o(vld[1]), .inst_o(insto[1]), .pc_o(pco[1]), .count(cnt[1]));

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[ds%0d] t=%0t got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Called at a negedge: drive, compare against the model, let the edge happen, advance the model.
    task automatic cycle(input logic r, input logic j, input logic e, input logic d,
                         input logic [31:0] ja, input logic [31:0] ea);
        logic exp_rce [2];
        rst = r; jce = j; excpt = e; deq = d; jaddr = ja; ejpc = ea;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_rce[k] = !r && !(j || e) && ((mq[k].size() < DEPTH) || (d && mq[k].size() > 0));
            rc[k] = rce[k];
            if (armed) begin
                chk("romCe",    k, {31'b0, rce[k]}, {31'b0, exp_rce[k]});
                chk("instAddr", k, iaddr[k], m_pc[k]);
                chk("valid",    k, {31'b0, vld[k]}, {31'b0, mq[k].size() != 0});
                chk("count",    k, {29'b0, cnt[k]}, 32'(mq[k].size()));
                chk("inst_o",   k, insto[k], mq[k].size() != 0 ? mq[k][0].inst : 32'h0);
                chk("pc_o",     k, pco[k],   mq[k].size() != 0 ? mq[k][0].pc   : 32'h0);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mq[k].delete(); m_pc[k] = 32'h0; m_pend[k] = 1'b0;
            end else if (e) begin
                mq[k].delete(); m_pc[k] = ea; m_pend[k] = 1'b0;
            end else if (j) begin
                if (k == 1 && mq[k].size() >= 2) begin
                    ent_t keep;
                    keep = mq[k][1];
                    mq[k].delete(); mq[k].push_back(keep);
                    m_pc[k] = ja; m_pend[k] = 1'b0;
                end else if (k == 1) begin
                    mq[k].delete(); m_pend[k] = 1'b1; m_tgt[k] = ja;
                end else begin
                    mq[k].delete(); m_pc[k] = ja;
                end
            end else begin
                if (d && mq[k].size() > 0) void'(mq[k].pop_front());
                if (exp_rce[k]) begin
                    mq[k].push_back('{pc: m_pc[k], inst: rom(m_pc[k])});
                    m_pc[k] = m_pend[k] ? m_tgt[k] : m_pc[k] + 32'd4;
                    m_pend[k] = 1'b0;
                end
            end
        end
        armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input logic d);
        cycle(1'b0, 1'b0, 1'b0, d, 32'h0, 32'h0);
    endtask

    // Reset, one push, then four streaming cycles: head 0x10, count 1, fetch pc 0x14.
    task automatic prep();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("stream_count", 0, {29'b0, cnt[0]}, 32'd1);
            chk("stream_pc",    0, pco[0], 32'(4 * (i + 1)));
        end
    endtask

    initial begin
        armed = 1'b0;
        rst = 1'b1; jce = 1'b0; excpt = 1'b0; deq = 1'b0; jaddr = '0; ejpc = '0;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_pend[k] = 1'b0; m_tgt[k] = 32'h0;
        end
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_count", 0, {29'b0, cnt[0]}, 32'd0);
        chk("rst_addr",  0, iaddr[0], 32'h0);
        chk("rst_valid", 0, {31'b0, vld[0]}, 32'd0);

        // Fill with deq low: exactly DEPTH fetches, then stall.
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            chk("fill_romce", 0, {31'b0, rc[0]}, (i < 4) ? 32'd1 : 32'd0);
        end
        chk("fill_count", 0, {29'b0, cnt[0]}, 32'd4);
        chk("fill_pc",    0, pco[0], 32'h0);
        chk("fill_inst",  0, insto[0], 32'h1234_5677);

        // Jump with three entries queued, head 0x10.
        prep();
        idle(1'b0);
        idle(1'b0);
        chk("pre_jump_count", 1, {29'b0, cnt[1]}, 32'd3);
        chk("pre_jump_pc",    1, pco[1], 32'h10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        chk("j0_count", 0, {29'b0, cnt[0]}, 32'd0);
        chk("j0_addr",  0, iaddr[0], 32'h100);
        chk("j1_count", 1, {29'b0, cnt[1]}, 32'd1);
        chk("j1_pc",    1, pco[1], 32'h14);
        chk("j1_addr",  1, iaddr[1], 32'h100);
        idle(1'b0);
        chk("j0_romce",  0, {31'b0, rc[0]}, 32'd1);
        chk("j0_headpc", 0, pco[0], 32'h100);
        chk("j0_valid",  0, {31'b0, vld[0]}, 32'd1);

        // Delay slot not yet fetched.
        prep();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        chk("pend_addr",  1, iaddr[1], 32'h14);
        chk("pend_count", 1, {29'b0, cnt[1]}, 32'd0);
        idle(1'b0);
        chk("pend_slot",  1, pco[1], 32'h14);
        chk("pend_tgt",   1, iaddr[1], 32'h100);

        // Exception beats a simultaneous jump and cancels the pending target.
        prep();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h80);
        chk("exc_count", 1, {29'b0, cnt[1]}, 32'd0);
        chk("exc_addr",  1, iaddr[1], 32'h80);
        idle(1'b0);
        chk("exc_head",  1, pco[1], 32'h80);
        chk("exc_next",  1, iaddr[1], 32'h84);

        // Reset while full after the pointers have wrapped.
        prep();
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk("wrap_full", 0, {29'b0, cnt[0]}, 32'd4);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("mid_rst_count", 0, {29'b0, cnt[0]}, 32'd0);
        chk("mid_rst_pc",    0, pco[0], 32'h0);
        chk("mid_rst_inst",  0, insto[0], 32'h0);
        chk("mid_rst_addr",  1, iaddr[1], 32'h0);
        idle(1'b0);
        chk("resume_romce",  0, {31'b0, rc[0]}, 32'd1);
        chk("resume_pc",     0, pco[0], 32'h0);

        // Random traffic, including targets near the top of the address space.
        for (int n = 0; n < 3000; n++) begin
            logic        r, j, e, d;
            logic [31:0] ja, ea;
            r  = ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 19) == 0);
            j  = ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 2) != 0);
            ja = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            ea = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
            cycle(r, j, e, d, ja, ea);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
